// File: rtl/engine_result_arbiter.sv
// Round-robin collector of finished Mandelbrot engine results onto the single pixel-memory
// write port, with per-frame pixel counting and out-of-range result detection.
module engine_result_arbiter #(
  parameter int NUM_PROC = 4,
  parameter int ITER_W   = 8,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                            cclk,
  input  logic                            creset,
  input  logic [NUM_PROC-1:0]             creq,
  input  logic [NUM_PROC*(19+ITER_W)-1:0] cres_bus,
  output logic [NUM_PROC-1:0]             cgnt,
  input  logic                            mem_ready,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [ITER_W-1:0]               wr_data,
  output logic                            frame_done,
  output logic [ADDR_W-1:0]               pix_count,
  output logic                            err_range
);
  localparam int SLICE_W = 19 + ITER_W;
  localparam int PTR_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam logic [PTR_W:0]        NP_W       = (PTR_W+1)'(NUM_PROC);
  localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(NUM_PROC - 1);
  localparam logic [NUM_PROC-1:0]   ONE_HOT0   = NUM_PROC'(1);
  localparam logic [ADDR_W-1:0]     H_RES_A    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0]     FRAME_LAST = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_win;
  logic [NUM_PROC-1:0] r_cgnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ITER_W-1:0]   r_wr_data;
  logic                r_frame_done;
  logic [ADDR_W-1:0]   r_pix_count;
  logic                r_err_range;

  logic [SLICE_W-1:0]  w_slices [NUM_PROC];
  logic [SLICE_W-1:0]  w_sel;
  logic [PTR_W:0]      w_idx;
  logic [PTR_W-1:0]    w_win_idx;
  logic                w_found;
  logic [9:0]          w_x;
  logic [8:0]          w_y;
  logic [ITER_W-1:0]   w_iter;
  logic                w_in_range;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_accept;
  logic [PTR_W-1:0]    w_ptr_after_win;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROC; gi++) begin : g_slice
      assign w_slices[gi] = cres_bus[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping modulo NUM_PROC.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= NP_W) w_idx = w_idx - NP_W;
      if (!w_found && creq[w_idx[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_sel      = w_slices[w_win_idx];
  assign w_x        = w_sel[SLICE_W-1 -: 10];
  assign w_y        = w_sel[ITER_W +: 9];
  assign w_iter     = w_sel[ITER_W-1:0];
  assign w_in_range = ({1'b0, w_x} < 11'(H_RES)) && ({1'b0, w_y} < 10'(V_RES));
  assign w_addr     = ADDR_W'(w_y) * H_RES_A + ADDR_W'(w_x);
  assign w_ptr_after_win = (r_win == LAST_PTR) ? '0 : r_win + PTR_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = w_in_range ? S_WRITE : S_DROP;
      S_WRITE: if (mem_ready) begin
                 w_state_next = S_IDLE;
                 w_accept     = 1'b1;
               end
      S_DROP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (creset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_win        <= '0;
      r_cgnt       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_pix_count  <= '0;
      r_err_range  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cgnt       <= '0;
      r_frame_done <= 1'b0;
      r_wr_en      <= (w_state_next == S_WRITE);
      // creq is only looked at in IDLE, so the grant cycle can never re-capture.
      if (r_state == S_IDLE && w_found) begin
        r_cgnt <= ONE_HOT0 << w_win_idx;
        r_win  <= w_win_idx;
        if (w_in_range) begin
          r_wr_addr <= w_addr;
          r_wr_data <= w_iter;
        end
      end
      if (w_accept) begin
        r_rr_ptr <= w_ptr_after_win;
        if (r_pix_count == FRAME_LAST) begin
          r_pix_count  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_pix_count <= r_pix_count + ADDR_W'(1);
        end
      end
      if (r_state == S_DROP) begin
        r_rr_ptr    <= w_ptr_after_win;
        r_err_range <= 1'b1;
      end
    end
  end

  assign cgnt       = r_cgnt;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign pix_count  = r_pix_count;
  assign err_range  = r_err_range;
endmodule
